// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Central stall/flush sequencer for a 5-stage pipeline. Every cycle it decides
//   the enable/flush pair of each pipeline latch and the PC enable. The inputs it
//   considers are fetch and data-memory handshakes, load-use hazards,
//   EX-resolved redirects and halt. It also counts stall cycles.
//
// Parameters
//   LOAD_BUBBLES  bubbles inserted per load-use hazard (1..3)
//   CNT_W         width of the stall-cycle counter
//
// Ports
//   CLK, nRST                  clock (rising edge), synchronous active-low reset
//   ihit                       instruction fetch completes this cycle
//   dmem_req, dhit             MEM-stage data access pending / completing
//   id_rs, id_rt, id_rt_used   source registers of the instruction in ID
//   ex_dREN, ex_wsel           load flag and destination of the instruction in EX
//   ex_redirect                taken branch/jump resolved in EX
//   mem_halt                   halt instruction in MEM
//   pc_en, *_en, *_flush       PC enable and latch controls (flush beats en in the latch)
//   halted                     sticky halt indication
//   stall_cycles               saturating count of non-halted cycles with pc_en=0
module pipeline_hazard_ctrl #(
   parameter int LOAD_BUBBLES = 1,
   parameter int CNT_W        = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dmem_req,
   input  logic             dhit,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_rt_used,
   input  logic             ex_dREN,
   input  logic [4:0]       ex_wsel,
   input  logic             ex_redirect,
   input  logic             mem_halt,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cycles
);

   typedef enum logic [1:0] {RUN, BUBBLE, DWAIT, HALTED} state_t;

   // Bubbles still owed after the hazard cycle itself.
   localparam logic [1:0] BUB_LOAD  = 2'(LOAD_BUBBLES - 1);
   localparam bit         MULTI_BUB = (LOAD_BUBBLES > 1);

   state_t           state_reg, state_next;
   logic [1:0]       bub_cnt_reg, bub_cnt_next;
   logic [CNT_W-1:0] stall_cnt_reg;

   logic dstall;
   logic lu;

   assign dstall = dmem_req & ~dhit;
   // $0 is hardwired to zero, so a load targeting it never creates a hazard.
   assign lu = ex_dREN & (ex_wsel != 5'd0) &
               ((ex_wsel == id_rs) | (id_rt_used & (ex_wsel == id_rt)));

   always_comb begin
      pc_en        = 1'b1;
      ifid_en      = 1'b1;
      idex_en      = 1'b1;
      exmem_en     = 1'b1;
      memwb_en     = 1'b1;
      ifid_flush   = 1'b0;
      idex_flush   = 1'b0;
      exmem_flush  = 1'b0;
      halted       = 1'b0;
      state_next   = state_reg;
      bub_cnt_next = bub_cnt_reg;

      case (state_reg)
         // DWAIT shares the RUN decision list: while the access is still
         // pending the dstall branch keeps everything frozen. On the dhit cycle
         // the list falls through to whatever is next, so there is no extra latency.
         RUN, DWAIT: begin
            state_next = RUN;
            if (mem_halt) begin
               pc_en      = 1'b0;
               ifid_en    = 1'b0;
               idex_en    = 1'b0;
               exmem_en   = 1'b0;
               state_next = HALTED;
            end else if (dstall) begin
               pc_en      = 1'b0;
               ifid_en    = 1'b0;
               idex_en    = 1'b0;
               exmem_en   = 1'b0;
               memwb_en   = 1'b0;
               state_next = DWAIT;
            end else if (ex_redirect) begin
               // Redirect beats a load-use hazard: the dependent ID
               // instruction is on the wrong path and is flushed anyway.
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
            end else if (lu) begin
               pc_en      = 1'b0;
               ifid_en    = 1'b0;
               idex_flush = 1'b1;
               if (MULTI_BUB) begin
                  bub_cnt_next = BUB_LOAD;
                  state_next   = BUBBLE;
               end
            end else if (!ihit) begin
               pc_en      = 1'b0;
               ifid_flush = 1'b1;
            end
         end

         // EX holds a bubble here, so ex_redirect is deliberately ignored.
         BUBBLE: begin
            if (mem_halt) begin
               pc_en      = 1'b0;
               ifid_en    = 1'b0;
               idex_en    = 1'b0;
               exmem_en   = 1'b0;
               state_next = HALTED;
            end else if (dstall) begin
               pc_en    = 1'b0;
               ifid_en  = 1'b0;
               idex_en  = 1'b0;
               exmem_en = 1'b0;
               memwb_en = 1'b0;
            end else begin
               pc_en        = 1'b0;
               ifid_en      = 1'b0;
               idex_flush   = 1'b1;
               bub_cnt_next = bub_cnt_reg - 2'd1;
               if (bub_cnt_reg == 2'd1) begin
                  state_next = RUN;
               end
            end
         end

         HALTED: begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
            halted   = 1'b1;
         end

         default: begin
            state_next = RUN;
         end
      endcase

      // Reset forces the whole pipe into a flushed, frozen condition.
      if (!nRST) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         idex_en     = 1'b0;
         exmem_en    = 1'b0;
         memwb_en    = 1'b0;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         exmem_flush = 1'b1;
         halted      = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_reg     <= RUN;
         bub_cnt_reg   <= 2'd0;
         stall_cnt_reg <= '0;
      end else begin
         state_reg   <= state_next;
         bub_cnt_reg <= bub_cnt_next;
         // The halt-entry cycle still counts because the state is not yet HALTED.
         if (!pc_en && (state_reg != HALTED) && (stall_cnt_reg != '1)) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
         end
      end
   end

   assign stall_cycles = stall_cnt_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl. Two instances share one stimulus stream:
// dut1 uses LOAD_BUBBLES=1 with a 32-bit counter, and dut3 uses LOAD_BUBBLES=3
// with a 4-bit counter so that counter saturation is reached. A behavioural
// model predicts the outputs, which are compared on every falling edge. Literal
// expectations pin key points.
module tb_pipeline_hazard_ctrl;

   logic       CLK = 1'b0;
   logic       nRST;
   logic       ihit, dmem_req, dhit, id_rt_used, ex_dREN, ex_redirect, mem_halt;
   logic [4:0] id_rs, id_rt, ex_wsel;

   logic        pc_en1, ifid_en1, idex_en1, exmem_en1, memwb_en1;
   logic        ifid_flush1, idex_flush1, exmem_flush1, halted1;
   logic [31:0] stall1;
   logic        pc_en3, ifid_en3, idex_en3, exmem_en3, memwb_en3;
   logic        ifid_flush3, idex_flush3, exmem_flush3, halted3;
   logic [3:0]  stall3;

   always #5 CLK = ~CLK;

   pipeline_hazard_ctrl #(.LOAD_BUBBLES(1), .CNT_W(32)) dut1 (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dmem_req(dmem_req), .dhit(dhit),
      .id_rs(id_rs), .id_rt(id_rt), .id_rt_used(id_rt_used),
      .ex_dREN(ex_dREN), .ex_wsel(ex_wsel), .ex_redirect(ex_redirect),
      .mem_halt(mem_halt), .pc_en(pc_en1), .ifid_en(ifid_en1),
      .idex_en(idex_en1), .exmem_en(exmem_en1), .memwb_en(memwb_en1),
      .ifid_flush(ifid_flush1), .idex_flush(idex_flush1),
      .exmem_flush(exmem_flush1), .halted(halted1), .stall_cycles(stall1)
   );

   pipeline_hazard_ctrl #(.LOAD_BUBBLES(3), .CNT_W(4)) dut3 (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dmem_req(dmem_req), .dhit(dhit),
      .id_rs(id_rs), .id_rt(id_rt), .id_rt_used(id_rt_used),
      .ex_dREN(ex_dREN), .ex_wsel(ex_wsel), .ex_redirect(ex_redirect),
      .mem_halt(mem_halt), .pc_en(pc_en3), .ifid_en(ifid_en3),
      .idex_en(idex_en3), .exmem_en(exmem_en3), .memwb_en(memwb_en3),
      .ifid_flush(ifid_flush3), .idex_flush(idex_flush3),
      .exmem_flush(exmem_flush3), .halted(halted3), .stall_cycles(stall3)
   );

   // Output vector layout: {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
   //                        ifid_flush, idex_flush, exmem_flush}
   logic [7:0] o1, o3;
   assign o1 = {pc_en1, ifid_en1, idex_en1, exmem_en1, memwb_en1,
                ifid_flush1, idex_flush1, exmem_flush1};
   assign o3 = {pc_en3, ifid_en3, idex_en3, exmem_en3, memwb_en3,
                ifid_flush3, idex_flush3, exmem_flush3};

   localparam logic [7:0] V_RESET  = 8'b00000_111;
   localparam logic [7:0] V_NORMAL = 8'b11111_000;
   localparam logic [7:0] V_FROZEN = 8'b00000_000;
   localparam logic [7:0] V_HALTIN = 8'b00001_000;
   localparam logic [7:0] V_REDIR  = 8'b11111_110;
   localparam logic [7:0] V_BUBBLE = 8'b00111_010;
   localparam logic [7:0] V_NOFET  = 8'b01111_100;

   int tests = 0;
   int fails = 0;
   bit checking = 1'b0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, got, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit      m_halted [2];
   int      m_bub    [2];
   longint  m_cnt    [2];
   int      m_lb     [2] = '{1, 3};
   longint  m_max    [2] = '{64'hFFFF_FFFF, 15};

   // Predicts this cycle's outputs for instance d and advances its model state
   // to what it should hold after the coming rising edge.
   task automatic model_step(input int d, output logic [7:0] o, output logic h);
      logic dst, luh;
      dst = dmem_req & ~dhit;
      luh = ex_dREN && (ex_wsel != 0) &&
            ((ex_wsel == id_rs) || (id_rt_used && (ex_wsel == id_rt)));
      h = m_halted[d];
      if (!nRST) begin
         o = V_RESET;
         h = 1'b0;
         m_halted[d] = 1'b0;
         m_bub[d]    = 0;
         m_cnt[d]    = 0;
         return;
      end
      if (m_halted[d]) begin
         o = V_FROZEN;
         return;
      end
      if (mem_halt) begin
         o = V_HALTIN;
         m_halted[d] = 1'b1;
      end else if (dst) begin
         o = V_FROZEN;
      end else if (m_bub[d] > 0) begin
         o = V_BUBBLE;
         m_bub[d]--;
      end else if (ex_redirect) begin
         o = V_REDIR;
      end else if (luh) begin
         o = V_BUBBLE;
         m_bub[d] = m_lb[d] - 1;
      end else if (!ihit) begin
         o = V_NOFET;
      end else begin
         o = V_NORMAL;
      end
      if (!o[7] && m_cnt[d] < m_max[d]) m_cnt[d]++;
   endtask

   always @(negedge CLK) begin
      if (checking) begin
         for (int d = 0; d < 2; d++) begin
            logic [7:0] eo;
            logic       eh;
            check($sformatf("dut%0d stall_cycles", d == 0 ? 1 : 3),
                  d == 0 ? 64'(stall1) : 64'(stall3), 64'(m_cnt[d]));
            model_step(d, eo, eh);
            check($sformatf("dut%0d outputs", d == 0 ? 1 : 3),
                  d == 0 ? 64'(o1) : 64'(o3), 64'(eo));
            check($sformatf("dut%0d halted", d == 0 ? 1 : 3),
                  d == 0 ? 64'(halted1) : 64'(halted3), 64'(eh));
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic idle();
      ihit = 1'b1; dmem_req = 1'b0; dhit = 1'b0;
      id_rs = 5'd1; id_rt = 5'd2; id_rt_used = 1'b1;
      ex_dREN = 1'b0; ex_wsel = 5'd5; ex_redirect = 1'b0; mem_halt = 1'b0;
   endtask

   task automatic load_use();
      idle();
      ex_dREN = 1'b1; ex_wsel = 5'd3; id_rs = 5'd3;
   endtask

   initial begin
      idle();
      nRST = 1'b0;
      tick(1);
      checking = 1'b1;
      tick(1);
      check("reset outputs", 64'(o1), 64'(V_RESET));
      check("reset halted", 64'(halted1), 64'd0);

      // Clean run
      nRST = 1'b1;
      idle();
      tick(10);
      check("clean stall1", 64'(stall1), 64'd0);
      check("clean stall3", 64'(stall3), 64'd0);

      // Load-use: lw $3 in EX, ID reads $3
      load_use();
      #1;
      check("lu bubble dut1", 64'(o1), 64'(V_BUBBLE));
      tick(1);
      idle();
      #1;
      check("lu second cycle dut1", 64'(o1), 64'(V_NORMAL));
      check("lu second cycle dut3", 64'(o3), 64'(V_BUBBLE));
      tick(4);
      check("lu stall1", 64'(stall1), 64'd1);
      check("lu stall3", 64'(stall3), 64'd3);

      // Load to $0 never stalls
      idle();
      ex_dREN = 1'b1; ex_wsel = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
      tick(2);
      check("r0 stall1", 64'(stall1), 64'd1);

      // Data stall for 4 cycles, redirect on the dhit cycle
      idle();
      dmem_req = 1'b1;
      tick(4);
      dhit = 1'b1; ex_redirect = 1'b1;
      #1;
      check("dhit redirect dut1", 64'(o1), 64'(V_REDIR));
      tick(1);
      idle();
      tick(2);
      check("dwait stall1", 64'(stall1), 64'd5);
      check("dwait stall3", 64'(stall3), 64'd7);

      // Data stall right after a load-use hazard freezes dut3's bubbles
      load_use();
      tick(1);
      idle();
      dmem_req = 1'b1;
      tick(2);
      idle();
      tick(4);
      check("bubble freeze stall3", 64'(stall3), 64'd12);

      // Redirect together with load-use: redirect wins, no bubble
      load_use();
      ex_redirect = 1'b1;
      #1;
      check("redir+lu dut3", 64'(o3), 64'(V_REDIR));
      tick(1);
      idle();
      tick(2);

      // Fetch miss alone
      ihit = 1'b0;
      #1;
      check("ihit low dut1", 64'(o1), 64'(V_NOFET));
      tick(1);
      idle();
      tick(1);

      // Long fetch miss drives dut3's counter into saturation
      ihit = 1'b0;
      tick(6);
      idle();
      tick(1);
      check("sat stall1", 64'(stall1), 64'd15);
      check("sat stall3", 64'(stall3), 64'd15);

      // Halt, then 20 cycles of activity that must be ignored
      mem_halt = 1'b1;
      #1;
      check("halt entry dut1", 64'(o1), 64'(V_HALTIN));
      tick(1);
      mem_halt = 1'b0; ihit = 1'b0; dmem_req = 1'b1;
      tick(20);
      check("halted dut1", 64'(halted1), 64'd1);
      check("halted stall1", 64'(stall1), 64'd16);
      check("halted stall3", 64'(stall3), 64'd15);

      // Reset leaves the halted state
      nRST = 1'b0;
      tick(1);
      nRST = 1'b1;
      idle();
      #1;
      check("post-reset halted", 64'(halted1), 64'd0);
      check("post-reset stall1", 64'(stall1), 64'd0);
      check("post-reset outputs", 64'(o1), 64'(V_NORMAL));
      tick(3);

      checking = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
